// File: rtl/btree_pkg.sv
// rtl/btree_pkg.sv - shared widths, lane type and saturating add for btree_reduce_8
// sat_add is used only when BTREE_REDUCE_SAT_EN is defined.
package btree_pkg;

  localparam int BTREE_WIDTH = 32;
  localparam int BTREE_LANES = 8;

  typedef logic [BTREE_WIDTH-1:0] lane_t;

  typedef struct packed {
    logic  sat;
    lane_t sum;
  } sat_sum_t;

  // Signed overflow happens only when both operands share a sign the wrapped sum lacks.
  function automatic sat_sum_t sat_add(input lane_t a, input lane_t b);
    sat_sum_t r;
    lane_t    wrap;
    wrap  = a + b;
    r.sat = (a[BTREE_WIDTH-1] == b[BTREE_WIDTH-1]) &&
            (wrap[BTREE_WIDTH-1] != a[BTREE_WIDTH-1]);
    if (r.sat) begin
      r.sum = a[BTREE_WIDTH-1] ? {1'b1, {(BTREE_WIDTH-1){1'b0}}}
                               : {1'b0, {(BTREE_WIDTH-1){1'b1}}};
    end else begin
      r.sum = wrap;
    end
    return r;
  endfunction

endpackage

// File: rtl/btree_reduce_8_if.sv
// rtl/btree_reduce_8_if.sv - vector input / scalar result handshake bundle
// slave is the reducer side, master is the producer/consumer side.
interface btree_reduce_8_if
  import btree_pkg::*;
#(
  parameter int WIDTH = BTREE_WIDTH,
  parameter int LANES = BTREE_LANES
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_sat;
  logic                   busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat, busy
  );

endinterface

// File: rtl/btree_add_level.sv
// rtl/btree_add_level.sv - one registered pairwise-add level of the reduction tree
// BTREE_REDUCE_SAT_EN selects saturating adds and builds the per-lane sat registers.
module btree_add_level
  import btree_pkg::*;
#(
  parameter int IN_LANES = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                up_valid_i,
  input  logic [IN_LANES*BTREE_WIDTH-1:0]     up_data_i,
  input  logic [IN_LANES-1:0]                 up_sat_i,
  input  logic                                dn_ready_i,
  output logic                                ready_o,
  output logic                                valid_o,
  output logic [(IN_LANES/2)*BTREE_WIDTH-1:0] data_o,
  output logic [IN_LANES/2-1:0]               sat_o
);

  localparam int W         = BTREE_WIDTH;
  localparam int OUT_LANES = IN_LANES / 2;

  logic                   valid_q, valid_d;
  logic [OUT_LANES*W-1:0] data_q, data_d;
  logic [OUT_LANES*W-1:0] sum_w;

  // An empty level always accepts, so bubbles collapse under a downstream stall.
  assign ready_o = dn_ready_i | ~valid_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;

`ifdef BTREE_REDUCE_SAT_EN
  logic [OUT_LANES-1:0] sat_w;
  logic [OUT_LANES-1:0] sat_q, sat_d;
`endif

  for (genvar j = 0; j < OUT_LANES; j++) begin : g_pair
    lane_t a, b;
    assign a = up_data_i[(2*j)*W +: W];
    assign b = up_data_i[(2*j+1)*W +: W];
`ifdef BTREE_REDUCE_SAT_EN
    sat_sum_t r;
    assign r                = sat_add(a, b);
    assign sum_w[j*W +: W]  = r.sum;
    assign sat_w[j]         = r.sat | up_sat_i[2*j] | up_sat_i[2*j+1];
`else
    assign sum_w[j*W +: W]  = a + b;
`endif
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = up_valid_i;
      if (up_valid_i) begin
        data_d = sum_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

`ifdef BTREE_REDUCE_SAT_EN
  always_comb begin
    sat_d = sat_q;
    if (ready_o && up_valid_i) begin
      sat_d = sat_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= '0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_o = sat_q;
`else
  logic unused_sat;
  assign unused_sat = ^up_sat_i;
  assign sat_o      = '0;
`endif

endmodule

// File: rtl/btree_reduce_8.sv
// rtl/btree_reduce_8.sv - 8-lane to 1-lane pipelined binary-tree adder
// Three btree_add_level stages; BTREE_REDUCE_SAT_EN enables signed saturation and out_sat.
module btree_reduce_8
  import btree_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  btree_reduce_8_if.slave bus
);

  localparam int W = BTREE_WIDTH;

  logic           ready1, ready2, ready3;
  logic           v1, v2, v3;
  logic [4*W-1:0] d1;
  logic [2*W-1:0] d2;
  logic [W-1:0]   d3;
  logic [3:0]     s1;
  logic [1:0]     s2;
  logic [0:0]     s3;

  btree_add_level #(.IN_LANES(BTREE_LANES)) u_l1 (
    .clk        (clk),
    .rst        (rst),
    .up_valid_i (bus.in_valid),
    .up_data_i  (bus.in_data),
    .up_sat_i   ({BTREE_LANES{1'b0}}),
    .dn_ready_i (ready2),
    .ready_o    (ready1),
    .valid_o    (v1),
    .data_o     (d1),
    .sat_o      (s1)
  );

  btree_add_level #(.IN_LANES(4)) u_l2 (
    .clk        (clk),
    .rst        (rst),
    .up_valid_i (v1),
    .up_data_i  (d1),
    .up_sat_i   (s1),
    .dn_ready_i (ready3),
    .ready_o    (ready2),
    .valid_o    (v2),
    .data_o     (d2),
    .sat_o      (s2)
  );

  btree_add_level #(.IN_LANES(2)) u_l3 (
    .clk        (clk),
    .rst        (rst),
    .up_valid_i (v2),
    .up_data_i  (d2),
    .up_sat_i   (s2),
    .dn_ready_i (bus.out_ready),
    .ready_o    (ready3),
    .valid_o    (v3),
    .data_o     (d3),
    .sat_o      (s3)
  );

  assign bus.in_ready  = ready1 & ~rst;
  assign bus.out_valid = v3;
  assign bus.out_data  = d3;
  assign bus.out_sat   = s3[0];
  assign bus.busy      = v1 | v2 | v3;

endmodule

// File: doc/btree_reduce_8.md
Name: btree_reduce_8

Overview:
- Pipelined 8-lane to 1-lane binary-tree adder with valid/ready flow control.
- Sits directly downstream of the 8-lane registered tree stage and consumes its eight 32-bit lane words.
- Reduces the lanes pairwise over three registered levels: 8 to 4, 4 to 2, 2 to 1.
- Full throughput of one vector per cycle; stalls cleanly under output backpressure.

Parameters:
- WIDTH, 32: lane and result width in bits.
- LANES, 8: input lane count. Fixed at 8; the tree depth of 3 is hard-wired.

Ports:
- clk  in  1  rising-edge clock (single clock domain).
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  in_data holds a vector.
- in_ready  out  1  block accepts the vector this cycle.
- in_data  in  LANES*WIDTH  lane i is in_data[i*WIDTH +: WIDTH].
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  reduced sum.
- out_sat  out  1  a saturation occurred somewhere in this result's tree (see Optional Feature).
- busy  out  1  OR of all three level valid bits.

Behaviour:
- Reset: synchronous on the clk edge with rst=1.
  - All level valid bits clear; all data and sat registers clear.
  - out_valid=0, out_data=0, out_sat=0, busy=0.
  - in_ready is forced to 0 while rst is high.
- Levels:
  - L1: 4 registers, L1[j] = lane 2j + lane 2j+1.
  - L2: 2 registers, L2[k] = L1[2k] + L1[2k+1].
  - L3: 1 register, L3 = L2[0] + L2[1]. L3 drives out_data directly.
- Pairing is fixed as above and never reordered.
- Handshake:
  - A transfer occurs when valid and ready are both 1 at the rising edge.
  - Per-level ready is combinational: ready3 = out_ready or not v3; ready2 = ready3 or not v2; ready1 = ready2 or not v1; in_ready = ready1 and not rst.
  - A level loads when it is ready. On load, its valid takes the upstream valid; if the upstream level is empty, a bubble is loaded.
  - A level that is not ready holds its data, valid and sat bits unchanged.
  - Bubbles collapse: an empty level accepts data even when downstream is stalled.
- Latency: a vector accepted in cycle t gives out_valid=1 in cycle t+3, provided there is no stall.
- Throughput: one vector per cycle when out_ready is held at 1.
- Ordering: results appear in acceptance order. No vector is dropped or duplicated.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.
- Capacity is 3 vectors. With out_ready=0, exactly 3 vectors are accepted before in_ready goes to 0.
- Arithmetic (default): unsigned modulo 2^WIDTH at every level; carries out are discarded.
- Reset mid-operation: all in-flight vectors are discarded and no partial result is emitted. in_ready returns to 1 in the first cycle after rst deasserts.
- in_data is ignored when in_valid=0.
- in_valid may be asserted without waiting for in_ready.

Optional Feature:
- Macro: BTREE_REDUCE_SAT_EN.
- Defined:
  - Each adder is a signed two's-complement saturating add, clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Each level carries a sat bit equal to the OR of the sat bits of its two operands and its own clamp event.
  - out_sat = the L3 sat bit.
- Undefined:
  - Wrapping add as described above.
  - out_sat is tied to 0 and no sat registers are built.
- Latency and handshake are identical in both builds.

Decomposition:
- Package btree_pkg holds:
  - BTREE_WIDTH = 32 and BTREE_LANES = 8.
  - A lane_t typedef of [WIDTH-1:0].
  - A function that returns the saturating signed sum together with its clamp flag.
- Sub-module btree_add_level: one level, parameterised by input lane count.
  - Contains the valid/ready register, pairwise adders and sat bits.
  - Instantiated three times, with input lane counts 8, 4 and 2.

Test Plan:
- Lanes 1..8, in_valid pulsed in cycle t with out_ready=1 -> out_valid=1 with out_data=36 in cycle t+3 only; busy is 1 in cycles t+1 to t+3.
- 20 back-to-back vectors v_n with all lanes = n, out_ready=1 -> out_data=8n in order, one per cycle, starting 3 cycles after the first accept.
- All lanes 0x2000_0000, default build -> out_data=0x0000_0000, out_sat=0.
- Same build, lanes 0xFFFF_FFFF -> out_data=0xFFFF_FFF8.
- BTREE_REDUCE_SAT_EN build:
  - All lanes 0x7FFF_FFFF -> out_data=0x7FFF_FFFF, out_sat=1.
  - All lanes 0x8000_0000 -> out_data=0x8000_0000, out_sat=1.
  - Lanes {-5, 5, 1, 2, 3, 4, 0, 0} -> out_data=10, out_sat=0.
- Continuous in_valid with out_ready=0 for 6 cycles -> exactly 3 accepts, then in_ready=0 and out_data is stable; after out_ready is raised, results drain in order with no loss.
- rst asserted for 1 cycle while 3 vectors are in flight -> next cycle has out_valid=0, busy=0 and nothing is emitted from the old vectors; a new vector of lanes=1 gives out_data=8 three cycles after it is accepted.
